// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - single-port instruction memory arbiter between fetch and loader/debug port.
// Optional IMEM_ARB_BOUND_CHECK_EN: reject out-of-range addresses (NOP read data, dropped write, l_err pulse).
module imem_port_arbiter #(
  parameter int          ADDR_W       = 8,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] NOP_WORD     = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [31:0]       f_addr,
  output logic              f_rsp_valid,
  output logic [31:0]       f_rsp_data,
  input  logic              l_req_valid,
  output logic              l_req_ready,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  input  logic              l_lock,
  output logic              l_rsp_valid,
  output logic [31:0]       l_rsp_data,
`ifdef IMEM_ARB_BOUND_CHECK_EN
  output logic              l_err,
`endif
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {RUN, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_f_q, rd_l_q;
  logic              rd_f_d, rd_l_d;
  logic [31:0]       f_hold_q, l_hold_q;
  logic              locked;
  logic              grant_f, grant_l;
  logic              oor;
  logic              go;
  logic [31:0]       rsp_word;

`ifdef IMEM_ARB_BOUND_CHECK_EN
  logic              nop_q, err_q;
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[1:0], l_addr[1:0]};
  assign oor      = grant_l ? (|l_addr[31:ADDR_W+2]) : (|f_addr[31:ADDR_W+2]);
  assign rsp_word = nop_q ? NOP_WORD : m_rdata;
  assign l_err    = err_q && !rst;
`else
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                              l_addr[31:ADDR_W+2], l_addr[1:0]};
  assign oor      = 1'b0;
  assign rsp_word = m_rdata;
`endif

  // Lock takes effect in the cycle l_lock rises; release is seen one cycle after it falls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    locked  = (state_q == LOCKED) || l_lock;
    grant_l = 1'b0;
    grant_f = 1'b0;

    case (state_q)
      RUN:     if (l_lock)  state_d = LOCKED;
      LOCKED:  if (!l_lock) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (!rst) begin
      grant_l = l_req_valid && (locked || !f_req_valid || cnt_q >= LIMIT);
      grant_f = f_req_valid && !locked && !grant_l;
    end

    if (!l_req_valid || grant_l) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign f_req_ready = grant_f;
  assign l_req_ready = grant_l;
  assign go          = (grant_f || grant_l) && !oor;

  always_comb begin
    m_en    = go;
    m_we    = go && grant_l && l_we;
    m_addr  = '0;
    m_wdata = '0;
    if (go) begin
      m_addr = grant_l ? l_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
    end
    if (go && grant_l && l_we) begin
      m_wdata = l_wdata;
    end
  end

  // Owner bits route next-cycle read data; out-of-range reads still respond.
  assign rd_f_d = grant_f;
  assign rd_l_d = grant_l && !l_we;

  assign f_rsp_valid = rd_f_q && !rst;
  assign l_rsp_valid = rd_l_q && !rst;
  assign f_rsp_data  = f_rsp_valid ? rsp_word : f_hold_q;
  assign l_rsp_data  = l_rsp_valid ? rsp_word : l_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      rd_f_q   <= 1'b0;
      rd_l_q   <= 1'b0;
      f_hold_q <= '0;
      l_hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_f_q  <= rd_f_d;
      rd_l_q  <= rd_l_d;
      if (rd_f_q) f_hold_q <= rsp_word;
      if (rd_l_q) l_hold_q <= rsp_word;
    end
  end

`ifdef IMEM_ARB_BOUND_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      nop_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      nop_q <= oor && (grant_f || grant_l);
      err_q <= oor && grant_l;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - table, directed and randomized checks of imem_port_arbiter against a reference model.
module tb_imem_port_arbiter;

  localparam int          ADDR_W = 8;
  localparam int          LIM    = 4;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk, rst;
  logic        f_req_valid, f_req_ready, f_rsp_valid;
  logic [31:0] f_addr, f_rsp_data;
  logic        l_req_valid, l_req_ready, l_we, l_lock, l_rsp_valid;
  logic [31:0] l_addr, l_wdata, l_rsp_data;
  logic        l_err;
  logic        m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIM), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_we(l_we),
    .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
`ifdef IMEM_ARB_BOUND_CHECK_EN
    .l_err(l_err),
`endif
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

`ifndef IMEM_ARB_BOUND_CHECK_EN
  assign l_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory behind the port: unwritten words read their address-derived seed.
  logic [31:0] mem [256];
  bit          written [256];
  always @(posedge clk) begin
    if (m_en && m_we) begin
      mem[m_addr]     <= m_wdata;
      written[m_addr] <= 1'b1;
    end
    if (m_en && !m_we) m_rdata <= written[m_addr] ? mem[m_addr] : init_word(int'(m_addr));
  end

  int tests, fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [256];
  int          cnt_m;
  bit          prev_lock;
  bit          pf, pl, perr;
  logic [31:0] pf_data, pl_data, hf, hl;

  logic        s_f_rsp_valid, s_l_rsp_valid, s_m_en, s_l_err;
  logic [31:0] s_f_rsp_data, s_l_rsp_data;
  bit          s_gf, s_gl;

  function automatic bit out_of_range(input logic [31:0] a);
    bit bc;
`ifdef IMEM_ARB_BOUND_CHECK_EN
    bc = 1'b1;
`else
    bc = 1'b0;
`endif
    return bc && (a[31:ADDR_W+2] != 0);
  endfunction

  task automatic model_reset();
    cnt_m = 0; prev_lock = 0; pf = 0; pl = 0; perr = 0;
    pf_data = 0; pl_data = 0; hf = 0; hl = 0;
  endtask

  task automatic step(input bit r, input bit fv, input logic [31:0] fa,
                      input bit lv, input bit lwe, input logic [31:0] la,
                      input logic [31:0] wd, input bit lk);
    bit locked, gl, gf, o, efv, elv;
    int idx_f, idx_l, idx;
    logic [31:0] efd, eld;
    rst = r; f_req_valid = fv; f_addr = fa; l_req_valid = lv; l_we = lwe;
    l_addr = la; l_wdata = wd; l_lock = lk;
    #4;
    locked = prev_lock || lk;
    gl = !r && lv && (locked || !fv || cnt_m >= LIM);
    gf = !r && fv && !locked && !gl;
    idx_f = int'(fa[ADDR_W+1:2]);
    idx_l = int'(la[ADDR_W+1:2]);
    idx   = gl ? idx_l : idx_f;
    o     = gl ? out_of_range(la) : (gf ? out_of_range(fa) : 1'b0);
    chk("f_req_ready", 32'(f_req_ready), 32'(gf));
    chk("l_req_ready", 32'(l_req_ready), 32'(gl));
    chk("m_en", 32'(m_en), 32'((gl || gf) && !o));
    chk("m_we", 32'(m_we), 32'(gl && lwe && !o));
    chk("m_addr", 32'(m_addr), ((gl || gf) && !o) ? idx : 0);
    chk("m_wdata", m_wdata, (gl && lwe && !o) ? wd : 32'h0);
    efv = pf && !r;
    elv = pl && !r;
    efd = efv ? pf_data : hf;
    eld = elv ? pl_data : hl;
    chk("f_rsp_valid", 32'(f_rsp_valid), 32'(efv));
    chk("f_rsp_data", f_rsp_data, efd);
    chk("l_rsp_valid", 32'(l_rsp_valid), 32'(elv));
    chk("l_rsp_data", l_rsp_data, eld);
    chk("l_err", 32'(l_err), 32'(perr && !r));
    s_f_rsp_valid = f_rsp_valid; s_f_rsp_data = f_rsp_data;
    s_l_rsp_valid = l_rsp_valid; s_l_rsp_data = l_rsp_data;
    s_m_en = m_en; s_l_err = l_err; s_gf = gf; s_gl = gl;
    if (r) begin
      model_reset();
    end else begin
      if (efv) hf = pf_data;
      if (elv) hl = pl_data;
      pf      = gf;
      pf_data = out_of_range(fa) ? NOP : ref_mem[idx_f];
      pl      = gl && !lwe;
      pl_data = out_of_range(la) ? NOP : ref_mem[idx_l];
      perr    = gl && out_of_range(la);
      if (gl && lwe && !out_of_range(la)) ref_mem[idx_l] = wd;
      if (!lv || gl) cnt_m = 0;
      else if (cnt_m < LIM) cnt_m = cnt_m + 1;
      prev_lock = lk;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit fv, lv, lwe, lk;
    logic [31:0] fa, la, wd;
    bit ef, el, efv, elv;
  } vec_t;

  vec_t vt [12];

  initial begin
    tests = 0; fails = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    idle(1); idle(1);

    // Reset state
    idle(0);
    chk("rst_f_rsp_valid", 32'(s_f_rsp_valid), 0);
    chk("rst_f_rsp_data", s_f_rsp_data, 0);
    chk("rst_l_rsp_data", s_l_rsp_data, 0);
    chk("rst_m_en", 32'(s_m_en), 0);

    // Fetch stream 0,4,8
    step(0, 1, 32'h0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    chk("stream_d0", s_f_rsp_data, init_word(0));
    step(0, 1, 32'h8, 0, 0, 0, 0, 0);
    chk("stream_d1", s_f_rsp_data, init_word(1));
    idle(0);
    chk("stream_d2", s_f_rsp_data, init_word(2));
    chk("stream_v2", 32'(s_f_rsp_valid), 1);

    // Reset while a read is in flight: no response pulse
    step(0, 1, 32'hC, 0, 0, 0, 0, 0);
    idle(1);
    chk("rst_drop_valid", 32'(s_f_rsp_valid), 0);
    idle(0);
    chk("rst_drop_data", s_f_rsp_data, 0);
    chk("rst_drop_valid2", 32'(s_f_rsp_valid), 0);

    // Contention, lock load, lock entry with fetch in flight
    for (int i = 0; i < 5; i++)
      vt[i] = '{1, 1, 0, 0, 32'(i * 4), 32'h20, 0, (i < 4), (i == 4), (i > 0), 0};
    vt[5]  = '{1, 1, 0, 0, 32'h14, 32'h24, 0, 1, 0, 0, 1};
    vt[6]  = '{1, 0, 0, 0, 32'h18, 32'h0, 0, 1, 0, 1, 0};
    vt[7]  = '{1, 1, 1, 1, 32'h1C, 32'h0, 32'h00500093, 0, 1, 1, 0};
    vt[8]  = '{1, 1, 0, 1, 32'h1C, 32'h0, 0, 0, 1, 0, 0};
    vt[9]  = '{1, 0, 0, 1, 32'h1C, 32'h0, 0, 0, 0, 0, 1};
    vt[10] = '{1, 0, 0, 0, 32'h1C, 32'h0, 0, 0, 0, 0, 0};
    vt[11] = '{1, 0, 0, 0, 32'h1C, 32'h0, 0, 1, 0, 0, 0};
    idle(1);
    for (int i = 0; i < 12; i++) begin
      step(0, vt[i].fv, vt[i].fa, vt[i].lv, vt[i].lwe, vt[i].la, vt[i].wd, vt[i].lk);
      chk($sformatf("tbl%0d_f_ready", i), 32'(s_gf), 32'(vt[i].ef));
      chk($sformatf("tbl%0d_l_ready", i), 32'(s_gl), 32'(vt[i].el));
      chk($sformatf("tbl%0d_f_rsp_valid", i), 32'(s_f_rsp_valid), 32'(vt[i].efv));
      chk($sformatf("tbl%0d_l_rsp_valid", i), 32'(s_l_rsp_valid), 32'(vt[i].elv));
      if (vt[i].elv && vt[i].lk) chk("lock_readback", s_l_rsp_data, 32'h00500093);
    end

`ifdef IMEM_ARB_BOUND_CHECK_EN
    step(0, 1, 32'h400, 0, 0, 0, 0, 0);
    chk("oor_fetch_m_en", 32'(s_m_en), 0);
    idle(0);
    chk("oor_fetch_data", s_f_rsp_data, NOP);
    step(0, 0, 0, 1, 1, 32'h400, 32'hDEADBEEF, 0);
    chk("oor_write_m_en", 32'(s_m_en), 0);
    idle(0);
    chk("oor_l_err", 32'(s_l_err), 1);
`endif

    // Randomized traffic against the model
    begin
      bit lk, r;
      logic [31:0] fa, la;
      lk = 0;
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(0, 19) == 0) lk = !lk;
        r  = ($urandom_range(0, 99) == 0);
        fa = {($urandom_range(0, 7) == 0) ? 22'($urandom) : 22'h0, 10'($urandom)};
        la = {($urandom_range(0, 7) == 0) ? 22'($urandom) : 22'h0, 10'($urandom)};
        step(r, ($urandom_range(0, 9) < 7), fa, ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 2) == 0), la, $urandom, lk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
